// File: rtl/cm3_matrix_input_hold.sv
// cm3_matrix_input_hold
// AHB bus-matrix input stage placed in front of a slave-port address decoder.
// A transfer is forwarded live when the decoder grants the output stage;
// otherwise its address phase is captured and the master is stalled until
// the output stage accepts it.

module cm3_matrix_input_hold #(
  parameter int ADDR_W = 32,
  parameter int USER_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic              HMASTLOCKS,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic [USER_W-1:0] HAUSERS,
  input  logic              HREADYS,
  input  logic              active_dec,
  input  logic              readyout_dec,
  input  logic [1:0]        resp_dec,
  output logic              sel_op,
  output logic [ADDR_W-1:0] addr_op,
  output logic [1:0]        trans_op,
  output logic              write_op,
  output logic              mastlock_op,
  output logic [2:0]        size_op,
  output logic [2:0]        burst_op,
  output logic [3:0]        prot_op,
  output logic [USER_W-1:0] auser_op,
  output logic              ready_op,
  output logic              held_tran_op,
  output logic              HREADYOUTS,
  output logic [1:0]        HRESPS
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HELD = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          trans_q, trans_d;
  logic                write_q, write_d;
  logic                mastlock_q, mastlock_d;
  logic [2:0]          size_q, size_d;
  logic [2:0]          burst_q, burst_d;
  logic [3:0]          prot_q, prot_d;
  logic [USER_W-1:0]   auser_q, auser_d;

  logic trans_req;
  logic issue;
  logic load;

  assign trans_req = HSELS & HTRANSS[1];
  assign issue     = trans_req & active_dec;
  assign load      = trans_req & ~active_dec;

  // Next-state and hold-register capture; the hold register only loads when a
  // completed master address phase cannot be granted to the output stage.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    trans_d    = trans_q;
    write_d    = write_q;
    mastlock_d = mastlock_q;
    size_d     = size_q;
    burst_d    = burst_q;
    prot_d     = prot_q;
    auser_d    = auser_q;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (HREADYS) begin
          if (issue) begin
            state_d = ST_DATA;
          end else if (load) begin
            state_d    = ST_HELD;
            addr_d     = HADDRS;
            trans_d    = HTRANSS;
            write_d    = HWRITES;
            mastlock_d = HMASTLOCKS;
            size_d     = HSIZES;
            burst_d    = HBURSTS;
            prot_d     = HPROTS;
            auser_d    = HAUSERS;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HELD: begin
        if (active_dec) begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and hold register; reset discards any held transfer.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      trans_q    <= '0;
      write_q    <= 1'b0;
      mastlock_q <= 1'b0;
      size_q     <= '0;
      burst_q    <= '0;
      prot_q     <= '0;
      auser_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      trans_q    <= trans_d;
      write_q    <= write_d;
      mastlock_q <= mastlock_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      prot_q     <= prot_d;
      auser_q    <= auser_d;
    end
  end

  // Forwarding mux to the decoder and response path back to the master.
  always_comb begin
    sel_op       = HSELS;
    addr_op      = HADDRS;
    trans_op     = HSELS ? HTRANSS : 2'b00;
    write_op     = HWRITES;
    mastlock_op  = HMASTLOCKS;
    size_op      = HSIZES;
    burst_op     = HBURSTS;
    prot_op      = HPROTS;
    auser_op     = HAUSERS;
    ready_op     = HREADYS;
    held_tran_op = 1'b0;
    HREADYOUTS   = 1'b1;
    HRESPS       = 2'b00;
    case (state_q)
      ST_HELD: begin
        sel_op       = 1'b1;
        addr_op      = addr_q;
        trans_op     = trans_q;
        write_op     = write_q;
        mastlock_op  = mastlock_q;
        size_op      = size_q;
        burst_op     = burst_q;
        prot_op      = prot_q;
        auser_op     = auser_q;
        ready_op     = 1'b1;
        held_tran_op = 1'b1;
        HREADYOUTS   = 1'b0;
      end
      ST_DATA: begin
        HREADYOUTS = readyout_dec;
        HRESPS     = resp_dec;
      end
      default: begin
        HREADYOUTS = 1'b1;
      end
    endcase
  end

endmodule
